// File: rtl/req_ack_throttle.sv
// req_ack_throttle: multi-channel req/ack pass-through shaper.
// Each channel gates both req (forward) and ack (reverse) with a registered
// gate bit driven by bypass / LFSR-random / periodic duty / full stall.
// Per-channel transfer counters, an idle watchdog and a sticky done flag
// support soak and backpressure testing of a downstream datapath block.
module req_ack_throttle #(
   parameter int          NUM_CH     = 2,
   parameter int          DW         = 16,
   parameter int          CNT_W      = 32,
   parameter int          IDLE_LIMIT = 100,
   parameter logic [15:0] SEED       = 16'hACE1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NUM_CH*DW-1:0]     t_dat,
   input  logic [NUM_CH-1:0]        t_req,
   output logic [NUM_CH-1:0]        t_ack,
   output logic [NUM_CH*DW-1:0]     i_dat,
   output logic [NUM_CH-1:0]        i_req,
   input  logic [NUM_CH-1:0]        i_ack,
   input  logic [1:0]               cfg_mode,
   input  logic [7:0]               cfg_duty,
   input  logic [CNT_W-1:0]         cfg_target,
   output logic [NUM_CH*CNT_W-1:0]  xfer_cnt,
   output logic [NUM_CH-1:0]        idle_to,
   output logic                     done
);

   typedef enum logic [1:0] {
      MODE_BYPASS = 2'd0,
      MODE_RANDOM = 2'd1,
      MODE_PERIOD = 2'd2,
      MODE_STALL  = 2'd3
   } mode_e;

   localparam int          IDLE_CLOG = $clog2(IDLE_LIMIT + 1);
   localparam int          IDLE_W    = (IDLE_CLOG > 8) ? IDLE_CLOG : 8;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   logic [7:0]        period_cnt;
   logic [NUM_CH-1:0] tgt_met;

   // data passes straight through; only the handshake is shaped
   assign i_dat = t_dat;

   // shared free-running period counter for the periodic duty mode
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         period_cnt <= 8'd0;
      end else begin
         period_cnt <= period_cnt + 8'd1;
      end
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      localparam logic [15:0] SEED_RAW = SEED ^ 16'(k);
      localparam logic [15:0] CH_SEED  = (SEED_RAW == 16'h0000) ? 16'h0001 : SEED_RAW;

      logic [15:0]       lfsr_q;
      logic              gate_q;
      logic              g_nxt;
      logic              xfer;
      logic              hold;
      logic [CNT_W-1:0]  cnt_q;
      logic [IDLE_W-1:0] idle_rem_q;
      logic              idle_to_q;

      assign i_req[k] = t_req[k] & gate_q;
      assign t_ack[k] = i_ack[k] & gate_q;
      assign xfer     = i_req[k] & i_ack[k];
      // an offered but unaccepted request freezes the gate so req never retracts
      assign hold     = i_req[k] & ~i_ack[k];

      assign xfer_cnt[k*CNT_W +: CNT_W] = cnt_q;
      assign idle_to[k]                 = idle_to_q;
      assign tgt_met[k]                 = (cnt_q >= cfg_target);

      // gate value the next update would load, per throttle mode
      always_comb begin
         g_nxt = 1'b0;
         case (cfg_mode)
            MODE_BYPASS: g_nxt = 1'b1;
            MODE_RANDOM: g_nxt = (lfsr_q[7:0] < cfg_duty);
            MODE_PERIOD: g_nxt = (period_cnt < cfg_duty);
            MODE_STALL:  g_nxt = 1'b0;
            default:     g_nxt = 1'b0;
         endcase
      end

      // Galois LFSR, free-running regardless of traffic
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            lfsr_q <= CH_SEED;
         end else begin
            lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
         end
      end

      // gate register, held while a request waits for acceptance
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            gate_q <= 1'b0;
         end else if (!hold) begin
            gate_q <= g_nxt;
         end
      end

      // saturating transfer counter
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            cnt_q <= '0;
         end else if (xfer && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end

      // idle watchdog: cycles remaining before the flag, reloaded by a transfer
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            idle_rem_q <= IDLE_W'(IDLE_LIMIT);
            idle_to_q  <= 1'b0;
         end else begin
            if (xfer) begin
               idle_rem_q <= IDLE_W'(IDLE_LIMIT);
            end else if (idle_rem_q != '0) begin
               idle_rem_q <= idle_rem_q - 1'b1;
            end
            if (!xfer && (idle_rem_q == IDLE_W'(1))) begin
               idle_to_q <= 1'b1;
            end
         end
      end
   end

   // sticky completion: all channels hit a non-zero target, or any watchdog fired
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         done <= 1'b0;
      end else if (((cfg_target != '0) && (&tgt_met)) || (|idle_to)) begin
         done <= 1'b1;
      end
   end

endmodule

// File: tb/tb_req_ack_throttle.sv
// Testbench for req_ack_throttle: a cycle model derived from the handshake
// rules is compared against the DUT on every falling edge, and directed
// scenarios add hand-computed expectations on top.
module tb_req_ack_throttle;

   localparam int          NUM_CH     = 2;
   localparam int          DW         = 16;
   localparam int          CNT_W      = 32;
   localparam int          IDLE_LIMIT = 100;
   localparam logic [15:0] SEED       = 16'hACE1;

   logic                    clk;
   logic                    reset_n;
   logic [NUM_CH*DW-1:0]    t_dat;
   logic [NUM_CH-1:0]       t_req;
   logic [NUM_CH-1:0]       t_ack;
   logic [NUM_CH*DW-1:0]    i_dat;
   logic [NUM_CH-1:0]       i_req;
   logic [NUM_CH-1:0]       i_ack;
   logic [1:0]              cfg_mode;
   logic [7:0]              cfg_duty;
   logic [CNT_W-1:0]        cfg_target;
   logic [NUM_CH*CNT_W-1:0] xfer_cnt;
   logic [NUM_CH-1:0]       idle_to;
   logic                    done;

   req_ack_throttle #(
      .NUM_CH(NUM_CH), .DW(DW), .CNT_W(CNT_W), .IDLE_LIMIT(IDLE_LIMIT), .SEED(SEED)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .t_dat(t_dat), .t_req(t_req), .t_ack(t_ack),
      .i_dat(i_dat), .i_req(i_req), .i_ack(i_ack),
      .cfg_mode(cfg_mode), .cfg_duty(cfg_duty), .cfg_target(cfg_target),
      .xfer_cnt(xfer_cnt), .idle_to(idle_to), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic        m_gate    [NUM_CH];
   logic [15:0] m_lfsr    [NUM_CH];
   logic [63:0] m_cnt     [NUM_CH];
   int          m_idle    [NUM_CH];
   logic        m_idle_to [NUM_CH];
   logic [7:0]  m_period;
   logic        m_done;

   function automatic logic [15:0] seed_of(input int k);
      logic [15:0] s;
      s = SEED ^ 16'(k);
      return (s == 16'h0000) ? 16'h0001 : s;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NUM_CH; k++) begin
         m_gate[k]    = 1'b0;
         m_lfsr[k]    = seed_of(k);
         m_cnt[k]     = 64'd0;
         m_idle[k]    = 0;
         m_idle_to[k] = 1'b0;
      end
      m_period = 8'd0;
      m_done   = 1'b0;
   endtask

   // advance the model across one rising edge using the inputs now applied
   task automatic model_step();
      logic all_met;
      logic any_to;
      logic xf;
      logic gn;
      all_met = (cfg_target != 0);
      any_to  = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (m_cnt[k] < 64'(cfg_target)) all_met = 1'b0;
         if (m_idle_to[k]) any_to = 1'b1;
      end
      if (all_met || any_to) m_done = 1'b1;
      for (int k = 0; k < NUM_CH; k++) begin
         xf = t_req[k] & m_gate[k] & i_ack[k];
         case (cfg_mode)
            2'd0:    gn = 1'b1;
            2'd1:    gn = (m_lfsr[k][7:0] < cfg_duty);
            2'd2:    gn = (m_period < cfg_duty);
            default: gn = 1'b0;
         endcase
         if (!(t_req[k] && m_gate[k] && !i_ack[k])) m_gate[k] = gn;
         if (xf && m_cnt[k] < ((64'd1 << CNT_W) - 1)) m_cnt[k] = m_cnt[k] + 1;
         if (xf) begin
            m_idle[k] = 0;
         end else begin
            m_idle[k] = m_idle[k] + 1;
            if (m_idle[k] >= IDLE_LIMIT) m_idle_to[k] = 1'b1;
         end
         m_lfsr[k] = m_lfsr[k][0] ? ((m_lfsr[k] >> 1) ^ 16'hB400) : (m_lfsr[k] >> 1);
      end
      m_period = m_period + 8'd1;
   endtask

   // compare process: falling edge, inputs are stable from posedge+1
   logic [NUM_CH-1:0]       e_req, e_ack, e_to;
   logic [NUM_CH*CNT_W-1:0] e_cnt;
   initial begin
      forever begin
         @(negedge clk);
         if (!reset_n) model_reset();
         for (int k = 0; k < NUM_CH; k++) begin
            e_req[k] = t_req[k] & m_gate[k];
            e_ack[k] = i_ack[k] & m_gate[k];
            e_to[k]  = m_idle_to[k];
            e_cnt[k*CNT_W +: CNT_W] = m_cnt[k][CNT_W-1:0];
         end
         chk("i_req", 64'(i_req), 64'(e_req));
         chk("t_ack", 64'(t_ack), 64'(e_ack));
         chk("i_dat", 64'(i_dat), 64'(t_dat));
         chk("xfer_cnt", 64'(xfer_cnt), 64'(e_cnt));
         chk("idle_to", 64'(idle_to), 64'(e_to));
         chk("done", 64'(done), 64'(m_done));
         if (reset_n) model_step();
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [CNT_W-1:0] cnt_of(input int k);
      return xfer_cnt[k*CNT_W +: CNT_W];
   endfunction

   // ends at posedge+1 with reset just released
   task automatic do_reset(input logic [1:0] mode, input logic [7:0] duty,
                           input logic [CNT_W-1:0] target);
      @(posedge clk);
      #1;
      reset_n    = 1'b0;
      t_req      = '0;
      i_ack      = '0;
      cfg_mode   = mode;
      cfg_duty   = duty;
      cfg_target = target;
      tick(2);
      reset_n = 1'b1;
   endtask

   logic [CNT_W-1:0] c0, c1, r1, r2;
   int run_len;
   logic seen_fall;
   logic prev_req;
   logic found;

   initial begin
      reset_n = 1'b0; t_dat = '0; t_req = '0; i_ack = '0;
      cfg_mode = 2'd0; cfg_duty = 8'd0; cfg_target = '0;
      #3;
      t_req = 2'b11; i_ack = 2'b11;
      #1;
      chk("rst_i_req", 64'(i_req), 64'h0);
      chk("rst_t_ack", 64'(t_ack), 64'h0);
      chk("rst_done", 64'(done), 64'h0);
      chk("rst_cnt", 64'(xfer_cnt), 64'h0);

      // bypass: 20 back-to-back words on ch0
      do_reset(2'd0, 8'd0, '0);
      i_ack = 2'b11;
      tick(1);
      chk("model_lfsr0", 64'(m_lfsr[0]), 64'hE270);
      chk("model_lfsr1", 64'(m_lfsr[1]), 64'h5670);
      chk("byp_t_ack_open", 64'(t_ack), 64'h3);
      t_req = 2'b01; t_dat = 32'hBEEF_1234;
      #1;
      chk("byp_comb_req", 64'(i_req), 64'h1);
      chk("byp_comb_dat", 64'(i_dat), 64'hBEEF_1234);
      for (int i = 0; i < 20; i++) begin
         t_req[0]    = 1'b1;
         t_dat[15:0] = 16'h1000 + 16'(i);
         tick(1);
      end
      t_req = '0;
      chk("byp_cnt20", 64'(cnt_of(0)), 64'd20);
      chk("model_cnt20", m_cnt[0], 64'd20);

      // stall with hold: random mode, then switch to stall mid-request
      do_reset(2'd1, 8'd128, '0);
      t_req = 2'b01; i_ack = 2'b00;
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick(1);
         if (i_req[0]) begin
            found = 1'b1;
            break;
         end
      end
      chk("hold_wait_req", 64'(found), 64'h1);
      cfg_mode = 2'd3;
      tick(5);
      chk("hold_req_kept", 64'(i_req[0]), 64'h1);
      i_ack = 2'b01;
      tick(1);
      chk("hold_drop", 64'(i_req[0]), 64'h0);
      chk("hold_cnt1", 64'(cnt_of(0)), 64'd1);
      tick(20);
      chk("stall_no_xfer", 64'(cnt_of(0)), 64'd1);
      t_req = '0; i_ack = '0;

      // periodic duty 64 over 1024 cycles
      do_reset(2'd2, 8'd64, '0);
      t_req = 2'b11; i_ack = 2'b11;
      tick(1);
      c0 = cnt_of(0); c1 = cnt_of(1);
      run_len = 0; seen_fall = 1'b0; prev_req = i_req[0];
      for (int i = 0; i < 1024; i++) begin
         tick(1);
         if (i_req[0]) run_len++;
         if (prev_req && !i_req[0]) begin
            if (seen_fall) chk("per_run64", 64'(run_len), 64'd64);
            seen_fall = 1'b1;
         end
         if (!i_req[0]) run_len = 0;
         prev_req = i_req[0];
      end
      chk("per_cnt0", 64'(cnt_of(0) - c0), 64'd256);
      chk("per_cnt1", 64'(cnt_of(1) - c1), 64'd256);

      // random duty 64 over 4096 cycles, twice from reset
      do_reset(2'd1, 8'd64, '0);
      t_req = 2'b11; i_ack = 2'b11;
      tick(4096);
      r1 = cnt_of(0);
      chk("rand_range", 64'((r1 >= 922) && (r1 <= 1126)), 64'h1);
      do_reset(2'd1, 8'd64, '0);
      t_req = 2'b11; i_ack = 2'b11;
      tick(4096);
      r2 = cnt_of(0);
      chk("rand_repeat", 64'(r2), 64'(r1));

      // target done
      do_reset(2'd0, 8'd0, 32'd5);
      i_ack = 2'b11;
      tick(1);
      t_req = 2'b11;
      tick(4);
      t_req = 2'b01;
      tick(1);
      t_req = 2'b00;
      tick(2);
      chk("tgt_cnt0", 64'(cnt_of(0)), 64'd5);
      chk("tgt_cnt1", 64'(cnt_of(1)), 64'd4);
      chk("tgt_done0", 64'(done), 64'h0);
      t_req = 2'b10;
      tick(1);
      t_req = 2'b00;
      chk("tgt_cnt1_5", 64'(cnt_of(1)), 64'd5);
      chk("tgt_done_lat", 64'(done), 64'h0);
      tick(1);
      chk("tgt_done1", 64'(done), 64'h1);
      tick(5);
      chk("tgt_sticky", 64'(done), 64'h1);

      // watchdog on silent channels
      do_reset(2'd0, 8'd0, '0);
      i_ack = 2'b11;
      tick(99);
      chk("wd_99", 64'(idle_to), 64'h0);
      tick(1);
      chk("wd_100", 64'(idle_to), 64'h3);
      chk("wd_done_lat", 64'(done), 64'h0);
      tick(1);
      chk("wd_done", 64'(done), 64'h1);

      // transfer at idle count 99 suppresses the flag
      do_reset(2'd0, 8'd0, '0);
      i_ack = 2'b11;
      tick(99);
      t_req = 2'b01;
      tick(1);
      t_req = 2'b00;
      chk("wd_race_flag", 64'(idle_to), 64'h2);
      chk("wd_race_cnt", 64'(cnt_of(0)), 64'd1);
      tick(1);
      chk("wd_race_done", 64'(done), 64'h1);
      tick(50);
      chk("wd_race_late", 64'(idle_to[0]), 64'h0);

      // reset mid-burst
      t_req = 2'b11;
      tick(3);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rmid_i_req", 64'(i_req), 64'h0);
      chk("rmid_t_ack", 64'(t_ack), 64'h0);
      chk("rmid_cnt", 64'(xfer_cnt), 64'h0);
      chk("rmid_idle_to", 64'(idle_to), 64'h0);
      chk("rmid_done", 64'(done), 64'h0);
      tick(1);
      reset_n = 1'b1;
      tick(3);
      chk("rmid_resume", 64'(cnt_of(0)), 64'd2);
      t_req = '0;
      tick(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/req_ack_throttle.md
Name: req_ack_throttle

Overview:
- NUM_CH-channel req/ack pass-through shaper placed between a stream source and a datapath block (e.g. reciprocal) for soak and backpressure testing.
- Each channel inserts throttle bubbles on both the forward (req) and reverse (ack) paths. The bubble pattern is bypass, LFSR-random, periodic duty, or full stall.
- Counts transfers per channel, runs an idle watchdog, and raises a sticky done when a target count is reached or the watchdog expires.
- Synthesizable; usable on FPGA as well as in simulation.

Parameters:
- NUM_CH, 2, number of independent channels
- DW, 16, data width per channel
- CNT_W, 32, width of per-channel transfer counter
- IDLE_LIMIT, 100, idle cycles after which a channel's watchdog fires
- SEED, 16'hACE1, base LFSR seed; channel k uses SEED ^ k, forced to 1 if the result is 0

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- t_dat  in  NUM_CH*DW  upstream data; channel k is bits [k*DW +: DW]
- t_req  in  NUM_CH  upstream valid
- t_ack  out  NUM_CH  upstream ready
- i_dat  out  NUM_CH*DW  downstream data, equal to t_dat combinationally
- i_req  out  NUM_CH  downstream valid
- i_ack  in  NUM_CH  downstream ready
- cfg_mode  in  2  0 = bypass, 1 = random, 2 = periodic, 3 = stall
- cfg_duty  in  8  gate-open threshold, 0..255
- cfg_target  in  CNT_W  transfers per channel required for done; 0 disables the target condition
- xfer_cnt  out  NUM_CH*CNT_W  per-channel transfer counts
- idle_to  out  NUM_CH  per-channel sticky watchdog flags
- done  out  1  sticky completion flag

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n. All state clears on reset_n low regardless of clk.
- Reset values: xfer_cnt = 0, idle_to = 0, done = 0, gate_q = 0, every LFSR = its seed, period counter = 0. During reset, i_req = 0 and t_ack = 0.
- Gating, per channel (combinational):
  - i_req[k] = t_req[k] & gate_q[k]
  - t_ack[k] = i_ack[k] & gate_q[k]
  - Zero added latency on data, req and ack.
- Transfer definition: a transfer on channel k occurs on a clk edge where i_req[k] & i_ack[k].
- Per-channel 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1 (tap mask 16'hB400). It advances every cycle out of reset, independent of traffic.
- Shared 8-bit period counter, free-running, wraps 255 -> 0.
- Next gate value g_nxt per mode:
  - mode 0: 1
  - mode 1: lfsr[7:0] < cfg_duty
  - mode 2: period_cnt < cfg_duty
  - mode 3: 0
- gate_q update rule:
  - Hold rule: if i_req[k] & ~i_ack[k], gate_q[k] keeps its value.
  - Otherwise gate_q[k] <= g_nxt.
  - The hold rule guarantees i_req never deasserts before acceptance while t_req stays high.
  - Applies in every mode, including a switch to mode 3 mid-transaction.
- cfg_duty = 0 in mode 1 or 2 keeps the gate closed.
- cfg_mode and cfg_duty changes take effect on the next gate_q update.
- xfer_cnt[k]: increments on each transfer and saturates at 2^CNT_W-1. It does not wrap.
- Idle counter per channel, 8 bits or clog2(IDLE_LIMIT+1) bits, whichever is larger:
  - Clears on a transfer, else increments, saturating.
  - When it reaches IDLE_LIMIT, idle_to[k] sets and stays set until reset.
  - Idle counting starts at the first cycle after reset deassertion.
- done:
  - Sets on the cycle after either (a) cfg_target != 0 and every xfer_cnt[k] >= cfg_target, or (b) any idle_to bit is set.
  - Sticky until reset.
  - Traffic is not blocked after done; counters keep running.
- Simultaneous events: a transfer on the same cycle the idle counter would reach IDLE_LIMIT clears the counter, and idle_to does not set.
- Reset mid-transfer: req/ack drop immediately (asynchronously); upstream is responsible for re-presenting data.

Test Plan:
- Bypass: mode 0, 20 back-to-back words on ch0 with i_ack = 1 -> i_req/t_ack follow combinationally, i_dat == t_dat, xfer_cnt[0] = 20.
- Stall plus hold: mode 1, cfg_duty = 128; while i_req[0] = 1 and i_ack = 0, switch to mode 3 -> i_req[0] stays 1 until i_ack rises, then drops the following cycle; no further transfers while in mode 3.
- Periodic duty: mode 2, cfg_duty = 64, t_req = 1, i_ack = 1 for 1024 cycles -> exactly 256 transfers, in runs of 64.
- Random duty: mode 1, cfg_duty = 64, 4096 cycles, continuous traffic -> transfer count within 1024 ± 10%; identical sequence across two runs with the same SEED.
- Target done: cfg_target = 5, NUM_CH = 2, ch0 sends 5 and ch1 sends 4 -> done = 0; ch1's 5th transfer -> done = 1 one cycle later and stays 1.
- Watchdog and reset: no traffic on ch1 for 100 cycles -> idle_to[1] = 1, done = 1; a transfer on the cycle of count 99 -> no flag; pulse reset_n low mid-burst -> all outputs 0 immediately, counters 0.
